// File: rtl/poly_pkg.sv
// Shared types and helpers for the Horner polynomial evaluator.
package poly_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest accumulator fmt_out can format; instances must stay within it.
  localparam int unsigned MAXW = 64;

  // Full-precision accumulator width: no intermediate Horner step can overflow it.
  function automatic int unsigned acc_width(input int unsigned xw, input int unsigned cw,
                                            input int unsigned deg);
    return cw + deg * xw + $clog2(deg + 1);
  endfunction

  // Narrows an accumulator to ow bits; returns {ovf, y} with y in the low bits.
  function automatic logic [MAXW:0] fmt_out(input logic [MAXW-1:0] acc, input int unsigned ow,
                                            input bit sat);
    logic            ovf;
    logic [MAXW-1:0] y;
    ovf = 1'b0;
    y   = '0;
    for (int unsigned i = 0; i < MAXW; i++) begin
      if (i >= ow && acc[i]) ovf = 1'b1;
    end
    for (int unsigned i = 0; i < MAXW; i++) begin
      if (i < ow) y[i] = (sat && ovf) ? 1'b1 : acc[i];
    end
    return {ovf, y};
  endfunction

endpackage

// File: rtl/poly_horner_eval_if.sv
// Sample/result handshake and coefficient write port of poly_horner_eval.
interface poly_horner_eval_if #(
  parameter int unsigned XW  = 3,
  parameter int unsigned CW  = 3,
  parameter int unsigned DEG = 3,
  parameter int unsigned OW  = 12
);
  localparam int unsigned IW = $clog2(DEG + 1);

  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] x_in;
  logic          coef_we;
  logic [IW-1:0] coef_idx;
  logic [CW-1:0] coef_wdata;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] y_out;
  logic          ovf;

  modport master (
    output in_valid, x_in, coef_we, coef_idx, coef_wdata, out_ready,
    input  in_ready, out_valid, y_out, ovf
  );

  modport slave (
    input  in_valid, x_in, coef_we, coef_idx, coef_wdata, out_ready,
    output in_ready, out_valid, y_out, ovf
  );

endinterface

// File: rtl/poly_coef_bank.sv
// Programmable coefficient bank plus the working copy snapshotted per sample.
module poly_coef_bank
  import poly_pkg::*;
#(
  parameter int unsigned CW  = 3,
  parameter int unsigned DEG = 3,
  parameter int unsigned IW  = $clog2(DEG + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [IW-1:0] idx,
  input  logic [CW-1:0] wdata,
  input  logic          snap,
  output logic [CW-1:0] bank [DEG+1],
  output logic [CW-1:0] work [DEG+1]
);

  // Out-of-range writes are dropped; the snapshot sees pre-write bank contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i <= DEG; i++) begin
        bank[i] <= '0;
        work[i] <= '0;
      end
    end else begin
      if (we && 32'(idx) <= DEG) bank[idx] <= wdata;
      if (snap) begin
        for (int unsigned i = 0; i <= DEG; i++) work[i] <= bank[i];
      end
    end
  end

endmodule

// File: rtl/poly_horner_eval.sv
// Sequential unsigned polynomial evaluator, one shared multiply-add (Horner).
module poly_horner_eval
  import poly_pkg::*;
#(
  parameter int unsigned XW  = 3,
  parameter int unsigned CW  = 3,
  parameter int unsigned DEG = 3,
  parameter int unsigned OW  = 12,
  parameter bit          SAT = 1'b1
) (
  input logic              clk,
  input logic              rst,
  poly_horner_eval_if.slave bus
);

  localparam int unsigned IW = $clog2(DEG + 1);
  localparam int unsigned AW = acc_width(XW, CW, DEG);
  localparam int unsigned PW = AW + XW;

  if (DEG < 1) begin : g_bad_deg
    $error("poly_horner_eval: DEG must be >= 1");
  end
  if (AW > MAXW || OW > MAXW) begin : g_bad_width
    $error("poly_horner_eval: accumulator or output wider than fmt_out supports");
  end

  state_t        state;
  logic [XW-1:0] x_w;
  logic [IW-1:0] step;
  logic [AW-1:0] acc;
  logic [OW-1:0] y_q;
  logic          ovf_q;
  logic [CW-1:0] bank [DEG+1];
  logic [CW-1:0] work [DEG+1];
  logic          accept;
  logic [PW-1:0] mac;
  logic [MAXW:0] fmt;

  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.y_out     = y_q;
  assign bus.ovf       = ovf_q;
  assign accept        = bus.in_valid && bus.in_ready;

  assign mac = PW'(acc) * PW'(x_w) + PW'(work[step]);
  assign fmt = fmt_out(MAXW'(mac[AW-1:0]), OW, SAT);

  poly_coef_bank #(
    .CW (CW),
    .DEG(DEG),
    .IW (IW)
  ) u_bank (
    .clk  (clk),
    .rst  (rst),
    .we   (bus.coef_we),
    .idx  (bus.coef_idx),
    .wdata(bus.coef_wdata),
    .snap (accept),
    .bank (bank),
    .work (work)
  );

  // FSM, step counter and accumulator; output is formatted on entry to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      x_w   <= '0;
      step  <= '0;
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      // Acceptance from IDLE and back-to-back acceptance from DONE share one load path.
      acc   <= AW'(bank[DEG]);
      x_w   <= bus.x_in;
      step  <= IW'(DEG - 1);
      state <= CALC;
    end else begin
      case (state)
        CALC: begin
          acc  <= mac[AW-1:0];
          step <= step - IW'(1);
          if (step == '0) begin
            state <= DONE;
            y_q   <= fmt[OW-1:0];
            ovf_q <= fmt[MAXW];
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_horner_eval.sv
// Directed bench for poly_horner_eval: three lockstep DEG=3 instances
// (OW=12 sat, OW=8 sat, OW=8 wrap) plus one DEG=2 instance.
module tb_poly_horner_eval;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, coef_we, out_ready;
  logic [2:0] x_in, coef_wdata;
  logic [1:0] coef_idx;
  logic       in_valid3, coef_we3, out_ready3;
  logic [2:0] x_in3, coef_wdata3;
  logic [1:0] coef_idx3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  poly_horner_eval_if #(.XW(3), .CW(3), .DEG(3), .OW(12)) b0 ();
  poly_horner_eval_if #(.XW(3), .CW(3), .DEG(3), .OW(8))  b1 ();
  poly_horner_eval_if #(.XW(3), .CW(3), .DEG(3), .OW(8))  b2 ();
  poly_horner_eval_if #(.XW(3), .CW(3), .DEG(2), .OW(12)) b3 ();

  assign b0.in_valid = in_valid;  assign b0.x_in = x_in;  assign b0.out_ready = out_ready;
  assign b0.coef_we = coef_we;    assign b0.coef_idx = coef_idx;  assign b0.coef_wdata = coef_wdata;
  assign b1.in_valid = in_valid;  assign b1.x_in = x_in;  assign b1.out_ready = out_ready;
  assign b1.coef_we = coef_we;    assign b1.coef_idx = coef_idx;  assign b1.coef_wdata = coef_wdata;
  assign b2.in_valid = in_valid;  assign b2.x_in = x_in;  assign b2.out_ready = out_ready;
  assign b2.coef_we = coef_we;    assign b2.coef_idx = coef_idx;  assign b2.coef_wdata = coef_wdata;
  assign b3.in_valid = in_valid3; assign b3.x_in = x_in3; assign b3.out_ready = out_ready3;
  assign b3.coef_we = coef_we3;   assign b3.coef_idx = coef_idx3; assign b3.coef_wdata = coef_wdata3;

  poly_horner_eval #(.XW(3), .CW(3), .DEG(3), .OW(12), .SAT(1'b1))
    d0 (.clk(clk), .rst(rst), .bus(b0));
  poly_horner_eval #(.XW(3), .CW(3), .DEG(3), .OW(8), .SAT(1'b1))
    d1 (.clk(clk), .rst(rst), .bus(b1));
  poly_horner_eval #(.XW(3), .CW(3), .DEG(3), .OW(8), .SAT(1'b0))
    d2 (.clk(clk), .rst(rst), .bus(b2));
  poly_horner_eval #(.XW(3), .CW(3), .DEG(2), .OW(12), .SAT(1'b1))
    d3 (.clk(clk), .rst(rst), .bus(b3));

  typedef struct {
    logic [2:0]  c3, c2, c1, c0, x;
    logic [11:0] y12;
    logic [7:0]  y8s, y8w;
    logic        o8;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [1:0] i, input logic [2:0] v);
    coef_we = 1'b1; coef_idx = i; coef_wdata = v;
    tick();
    coef_we = 1'b0;
  endtask

  task automatic load4(input logic [2:0] c3, input logic [2:0] c2, input logic [2:0] c1,
                       input logic [2:0] c0);
    write_coef(2'd3, c3); write_coef(2'd2, c2); write_coef(2'd1, c1); write_coef(2'd0, c0);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (b0.out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (b0.out_valid !== 1'b1) check("out_valid_timeout", 0, 1);
  endtask

  // Offer x from IDLE, return edges from acceptance to out_valid.
  task automatic run(input logic [2:0] x, output int lat);
    in_valid = 1'b1; x_in = x;
    check("in_ready_idle", 32'(b0.in_ready), 1);
    tick();
    in_valid = 1'b0;
    wait_out(lat);
  endtask

  task automatic write3(input logic [1:0] i, input logic [2:0] v);
    coef_we3 = 1'b1; coef_idx3 = i; coef_wdata3 = v;
    tick();
    coef_we3 = 1'b0;
  endtask

  task automatic run3(input logic [2:0] x, output int lat);
    in_valid3 = 1'b1; x_in3 = x;
    tick();
    in_valid3 = 1'b0;
    lat = 0;
    while (b3.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, n, seen;

    //            c3 c2 c1 c0 x   y12   y8s  y8w  o8
    vt[0]  = '{3'd1, 3'd0, 3'd0, 3'd7, 3'd4, 12'd71,   8'd71,  8'd71,  1'b0};
    vt[1]  = '{3'd1, 3'd0, 3'd0, 3'd7, 3'd7, 12'd350,  8'd255, 8'd94,  1'b1};
    vt[2]  = '{3'd1, 3'd0, 3'd0, 3'd7, 3'd2, 12'd15,   8'd15,  8'd15,  1'b0};
    vt[3]  = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 12'd2800, 8'd255, 8'd240, 1'b1};
    vt[4]  = '{3'd5, 3'd6, 3'd3, 3'd2, 3'd0, 12'd2,    8'd2,   8'd2,   1'b0};
    vt[5]  = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd3, 12'd98,   8'd98,  8'd98,  1'b0};
    vt[6]  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 12'd0,    8'd0,   8'd0,   1'b0};
    vt[7]  = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 12'd7,    8'd7,   8'd7,   1'b0};
    vt[8]  = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd7, 12'd7,    8'd7,   8'd7,   1'b0};
    vt[9]  = '{3'd4, 3'd0, 3'd0, 3'd0, 3'd7, 12'd1372, 8'd255, 8'd92,  1'b1};
    vt[10] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 12'd255,  8'd255, 8'd255, 1'b0};
    vt[11] = '{3'd4, 3'd0, 3'd0, 3'd0, 3'd4, 12'd256,  8'd255, 8'd0,   1'b1};
    vt[12] = '{3'd0, 3'd7, 3'd0, 3'd3, 3'd5, 12'd178,  8'd178, 8'd178, 1'b0};

    rst = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    x_in = '0; coef_idx = '0; coef_wdata = '0;
    in_valid3 = 1'b0; coef_we3 = 1'b0; out_ready3 = 1'b1;
    x_in3 = '0; coef_idx3 = '0; coef_wdata3 = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(b0.out_valid), 0);
    check("rst_y_out", 32'(b0.y_out), 0);
    check("rst_ovf", 32'(b1.ovf), 0);
    check("rst_in_ready", 32'(b0.in_ready), 1);

    // Table: coefficients, x, expected outputs across all three DEG=3 variants.
    for (int i = 0; i < 13; i++) begin
      load4(vt[i].c3, vt[i].c2, vt[i].c1, vt[i].c0);
      run(vt[i].x, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 3);
      check($sformatf("v%0d_y12", i), 32'(b0.y_out), 32'(vt[i].y12));
      check($sformatf("v%0d_ovf12", i), 32'(b0.ovf), 0);
      check($sformatf("v%0d_y8sat", i), 32'(b1.y_out), 32'(vt[i].y8s));
      check($sformatf("v%0d_ovf8sat", i), 32'(b1.ovf), 32'(vt[i].o8));
      check($sformatf("v%0d_y8wrap", i), 32'(b2.y_out), 32'(vt[i].y8w));
      check($sformatf("v%0d_ovf8wrap", i), 32'(b2.ovf), 32'(vt[i].o8));
      tick();
      check($sformatf("v%0d_out_valid_drop", i), 32'(b0.out_valid), 0);
    end

    // Back-to-back: x=7 then x=2 offered continuously.
    load4(3'd1, 3'd0, 3'd0, 3'd7);
    in_valid = 1'b1; x_in = 3'd7;
    tick();
    x_in = 3'd2;
    check("b2b_in_ready_calc", 32'(b0.in_ready), 0);
    wait_out(n);
    check("b2b_lat1", 32'(n), 3);
    check("b2b_y1", 32'(b0.y_out), 350);
    check("b2b_in_ready_done", 32'(b0.in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("b2b_done_one_cycle", 32'(b0.out_valid), 0);
    wait_out(n);
    check("b2b_spacing", 32'(n + 1), 4);
    check("b2b_y2", 32'(b0.y_out), 15);
    tick();

    // Backpressure: hold in DONE for 5 cycles with a new sample pending.
    out_ready = 1'b0;
    run(3'd4, lat);
    in_valid = 1'b1; x_in = 3'd2;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_out_valid", k), 32'(b0.out_valid), 1);
      check($sformatf("bp%0d_y_out", k), 32'(b0.y_out), 71);
      check($sformatf("bp%0d_in_ready", k), 32'(b0.in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(b0.in_ready), 1);
    tick();
    in_valid = 1'b0;
    wait_out(n);
    check("bp_next_lat", 32'(n), 3);
    check("bp_next_y", 32'(b0.y_out), 15);
    tick();

    // Coefficient write on the accepting edge: snapshot keeps the old c0.
    load4(3'd1, 3'd0, 3'd0, 3'd0);
    in_valid = 1'b1; x_in = 3'd1;
    coef_we = 1'b1; coef_idx = 2'd0; coef_wdata = 3'd5;
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    wait_out(n);
    check("race_old_c0", 32'(b0.y_out), 1);
    tick();
    run(3'd1, lat);
    check("race_new_c0", 32'(b0.y_out), 6);
    tick();

    // Reset with a same-edge coefficient write: reset wins.
    rst = 1'b1; coef_we = 1'b1; coef_idx = 2'd0; coef_wdata = 3'd5;
    tick();
    rst = 1'b0; coef_we = 1'b0;
    run(3'd0, lat);
    check("rst_over_we_c0", 32'(b0.y_out), 0);
    tick();

    // Reset mid-CALC: sample discarded, bank cleared.
    load4(3'd1, 3'd0, 3'd0, 3'd7);
    in_valid = 1'b1; x_in = 3'd3;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midcalc_in_ready", 32'(b0.in_ready), 1);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (b0.out_valid === 1'b1) seen = 1;
      tick();
    end
    check("midcalc_no_out_valid", 32'(seen), 0);
    run(3'd3, lat);
    check("midcalc_cleared_y", 32'(b0.y_out), 0);
    tick();

    // DEG=2 instance: out-of-range index ignored, latency 2, ovf stuck at 0.
    write3(2'd3, 3'd7);
    write3(2'd2, 3'd1);
    run3(3'd0, lat);
    check("deg2_idx3_ignored", 32'(b3.y_out), 0);
    tick();
    run3(3'd2, lat);
    check("deg2_latency", 32'(lat), 2);
    check("deg2_y", 32'(b3.y_out), 4);
    tick();
    write3(2'd1, 3'd7); write3(2'd0, 3'd7); write3(2'd2, 3'd7);
    run3(3'd7, lat);
    check("deg2_full_y", 32'(b3.y_out), 399);
    check("deg2_full_ovf", 32'(b3.ovf), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
